guarded_word_receiver: RTL

- Receive end of the guarded-output interface. Consumes 32-bit words that an upstream guarded producer releases under a visibility qualifier, tags each word with the local phase, buffers it in a small FIFO and hands it to a public consumer over valid/ready.
- A scrub request zero-fills the buffer over several cycles, so no stale secret-derived data survives a declassification abort.
- Every output is forced to zero whenever it is not valid, so the information-flow checkers see no spurious flows.

---
 rtl/guarded_word_receiver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/guarded_word_receiver.sv
// Receive side of the guarded-output interface: phase-tagged FIFO with a
// multi-cycle zero-fill scrub and outputs masked to zero whenever not valid.
module guarded_word_receiver #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_visible,
  input  logic [WIDTH-1:0] in_data,
  input  logic             scrub,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_phase,
  output logic [1:0]       phase,
  output logic             full,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mem_data  [DEPTH];
  logic [1:0]       mem_phase [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, flush_idx;
  logic [AW:0]      count;

  logic running, start_flush, flush_last;
  logic push_req, pop, accept, drop;

  assign running     = (state == RUN);
  assign start_flush = running && scrub;
  assign flush_last  = (state == FLUSH) && (flush_idx == LAST_IDX);

  // Zero words carry no information, so they are neither stored nor dropped.
  assign push_req  = running && !scrub && in_visible && (in_data != '0);
  assign out_valid = running && (count != '0);
  assign pop       = out_valid && out_ready && !scrub;
  assign full      = (count == FULL_COUNT);
  assign accept    = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign busy      = (state == FLUSH);

  assign out_data  = out_valid ? mem_data[rd_ptr]  : '0;
  assign out_phase = out_valid ? mem_phase[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples pre-edge values regardless of block order.
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      RUN:     if (start_flush) state_next = FLUSH;
      FLUSH:   if (flush_last)  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end

  // Index wraps back to zero after the last entry because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              flush_idx <= '0;
    else if (start_flush)    flush_idx <= '0;
    else if (state == FLUSH) flush_idx <= flush_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: storage is reset too, so no X or stale secret can ever reach the
    // masked outputs; this costs reset fan-out on every entry.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_phase[i] <= '0;
      end
    end else if (state == FLUSH) begin
      mem_data[flush_idx]  <= '0;
      mem_phase[flush_idx] <= '0;
    end else if (accept) begin
      mem_data[wr_ptr]  <= in_data;
      mem_phase[wr_ptr] <= phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      phase <= '0;
    else if (enable) phase <= phase + 2'd1;
  end

  // Saturating: a wrapped counter would under-report loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         drop_count <= '0;
    else if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
  end

endmodule
